// File: rtl/p7_trace_pkg.sv
// Shared constants for the p7 instruction trace buffer: capture modes and FSM state encoding.
package p7_trace_pkg;

   localparam logic [1:0] MODE_STOP_FULL = 2'd0;
   localparam logic [1:0] MODE_RING      = 2'd1;
   localparam logic [1:0] MODE_TRIGGER   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_POST   = 2'd2,
      ST_FROZEN = 2'd3
   } state_e;

   // The unused encoding 3 is folded onto RING so the buffer never sees an undefined mode.
   function automatic logic [1:0] eff_mode(input logic [1:0] m);
      logic [1:0] r;
      case (m)
         MODE_STOP_FULL: r = MODE_STOP_FULL;
         MODE_TRIGGER:   r = MODE_TRIGGER;
         default:        r = MODE_RING;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/p7_trace_ram.sv
// Trace storage: DEPTH x W array, synchronous write, asynchronous read.
module p7_trace_ram #(
   parameter int DEPTH = 8,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem_q [DEPTH];

   // Entry write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/p7_trace_buf.sv
// Instruction trace buffer: captures retired PC/IR pairs in STOP_FULL, RING or TRIGGER mode,
// then drains them oldest-first once frozen.
module p7_trace_buf
   import p7_trace_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PC_W  = 32,
   parameter int IR_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cap_valid,
   input  logic [PC_W-1:0]            cap_pc,
   input  logic [IR_W-1:0]            cap_ir,
   input  logic [1:0]                 mode,
   input  logic                       arm,
   input  logic                       stop,
   input  logic [PC_W-1:0]            trig_pc,
   input  logic [$clog2(DEPTH)-1:0]   post_cnt,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [PC_W-1:0]            rd_pc,
   output logic [IR_W-1:0]            rd_ir,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       triggered,
   output logic                       overflow,
   output logic                       frozen
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW-1:0] PTR_ZERO = AW'(0);

   state_e          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_q, post_d;
   logic [AW:0]     count_q, count_d;
   logic            trig_q, trig_d, ovf_q, ovf_d;
   logic            full_q, full_d, empty_q, empty_d, rd_valid_q, rd_valid_d, frozen_q, frozen_d;
   logic [1:0]      cur_mode;
   logic            capturing, do_write, do_pop, drop_full, trig_hit, fill_stop;
   logic [PC_W+IR_W-1:0] rdata;

   // Decode which capture/readout actions happen this cycle.
   always_comb begin
      cur_mode  = eff_mode(mode);
      capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
      do_write  = !arm && cap_valid && capturing &&
                  !((cur_mode == MODE_STOP_FULL) && (count_q == CNT_FULL));
      drop_full = !arm && cap_valid && (state_q != ST_IDLE) &&
                  (cur_mode == MODE_STOP_FULL) && (count_q == CNT_FULL);
      trig_hit  = do_write && (state_q == ST_ARMED) && (cur_mode == MODE_TRIGGER) &&
                  (cap_pc == trig_pc);
      fill_stop = do_write && (cur_mode == MODE_STOP_FULL) && (count_q == CNT_FULL - CNT_ONE);
      do_pop    = !arm && rd_valid_q && rd_ready;
   end

   // Next-state logic; arm wins over everything, stop only matters while capturing.
   always_comb begin
      state_d = state_q;
      if (arm) begin
         state_d = ST_ARMED;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
            ST_ARMED: begin
               if (stop || fill_stop || (trig_hit && (post_cnt == PTR_ZERO))) begin
                  state_d = ST_FROZEN;
               end else if (trig_hit) begin
                  state_d = ST_POST;
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_POST: begin
               if (stop || fill_stop || (do_write && (post_q == PTR_ONE))) begin
                  state_d = ST_FROZEN;
               end else begin
                  state_d = ST_POST;
               end
            end
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Pointer, occupancy, post counter and sticky flag updates.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      post_d   = post_q;
      trig_d   = trig_q;
      ovf_d    = ovf_q;
      if (arm) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
         count_d  = {(AW+1){1'b0}};
         trig_d   = 1'b0;
         ovf_d    = 1'b0;
      end else if (do_write) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (count_q == CNT_FULL) begin
            // Wrap-around: the oldest entry is overwritten, so the read side moves with it.
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            ovf_d    = 1'b1;
         end else begin
            count_d = count_q + CNT_ONE;
         end
         if (trig_hit) begin
            trig_d = 1'b1;
            post_d = post_cnt;
         end else if (state_q == ST_POST) begin
            post_d = post_q - PTR_ONE;
         end else begin
            post_d = post_q;
         end
      end else if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         count_d  = count_q - CNT_ONE;
      end else if (drop_full) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Registered status outputs derived from the next state and occupancy.
   always_comb begin
      frozen_d   = (state_d == ST_FROZEN);
      rd_valid_d = frozen_d && (count_d != {(AW+1){1'b0}});
      full_d     = (count_d == CNT_FULL);
      empty_d    = (count_d == {(AW+1){1'b0}});
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q   <= PTR_ZERO;
         rd_ptr_q   <= PTR_ZERO;
         post_q     <= PTR_ZERO;
         count_q    <= {(AW+1){1'b0}};
         trig_q     <= 1'b0;
         ovf_q      <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         rd_valid_q <= 1'b0;
         frozen_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         post_q     <= post_d;
         count_q    <= count_d;
         trig_q     <= trig_d;
         ovf_q      <= ovf_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         rd_valid_q <= rd_valid_d;
         frozen_q   <= frozen_d;
      end
   end

   p7_trace_ram #(.DEPTH(DEPTH), .W(PC_W + IR_W)) u_ram (
      .clk   (clk),
      .we    (do_write),
      .waddr (wr_ptr_q),
      .wdata ({cap_pc, cap_ir}),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   assign rd_pc     = rdata[PC_W+IR_W-1:IR_W];
   assign rd_ir     = rdata[IR_W-1:0];
   assign rd_valid  = rd_valid_q;
   assign count     = count_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign triggered = trig_q;
   assign overflow  = ovf_q;
   assign frozen    = frozen_q;

endmodule

// File: tb/tb_p7_trace_buf.sv
// Scoreboard bench for p7_trace_buf (DEPTH=8): expected readout entries are queued as
// captures are driven and compared as the buffer drains.
module tb_p7_trace_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cap_valid = 1'b0;
   logic [31:0] cap_pc = 32'd0;
   logic [31:0] cap_ir = 32'd0;
   logic [1:0]  mode = 2'd0;
   logic        arm = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] trig_pc = 32'd0;
   logic [2:0]  post_cnt = 3'd0;
   logic        rd_ready = 1'b0;
   logic        rd_valid;
   logic [31:0] rd_pc, rd_ir;
   logic [3:0]  count;
   logic        full, empty, triggered, overflow, frozen;

   int n_total = 0;
   int n_bad   = 0;
   logic [63:0] sb[$];

   p7_trace_buf #(.DEPTH(8), .PC_W(32), .IR_W(32)) dut (
      .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_ir(cap_ir),
      .mode(mode), .arm(arm), .stop(stop), .trig_pc(trig_pc), .post_cnt(post_cnt),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_ir(rd_ir),
      .count(count), .full(full), .empty(empty), .triggered(triggered),
      .overflow(overflow), .frozen(frozen)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ir_of(input logic [31:0] pc);
      return pc ^ 32'hA5C3_0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic capture(input logic [31:0] pc);
      cap_valid = 1'b1;
      cap_pc    = pc;
      cap_ir    = ir_of(pc);
      tick();
      cap_valid = 1'b0;
   endtask

   task automatic expect_pc(input logic [31:0] pc);
      sb.push_back({pc, ir_of(pc)});
   endtask

   // toggle=1 drives rd_ready in a 1,0,1 repeating pattern
   task automatic readout(input string tag, input bit toggle);
      int budget = 100;
      int i = 0;
      logic [63:0] exp;
      while (sb.size() > 0 && budget > 0) begin
         rd_ready = (!toggle) || ((i % 3) != 1);
         if (rd_ready && rd_valid) begin
            exp = sb.pop_front();
            check_eq({tag, "_entry"}, {rd_pc, rd_ir}, exp);
         end
         tick();
         i++;
         budget--;
      end
      rd_ready = 1'b0;
      check_eq({tag, "_left"}, 64'(sb.size()), 64'd0);
      sb.delete();
      check_eq({tag, "_empty"}, {63'd0, empty}, 64'd1);
      check_eq({tag, "_rdv0"}, {63'd0, rd_valid}, 64'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_count"}, {60'd0, count}, 64'd0);
      check_eq({tag, "_flags"}, {58'd0, empty, full, rd_valid, triggered, overflow, frozen},
               64'b100000);
   endtask

   initial begin
      rst = 1'b0;
      tick();
      tick();
      check_reset_vals("reset");
      rst = 1'b1;
      tick();

      // STOP_FULL: freezes on the 8th write, later captures only flag overflow
      mode = 2'd0;
      pulse_arm();
      check_eq("sf_armed_count", {60'd0, count}, 64'd0);
      for (int k = 0; k < 10; k++) begin
         capture(32'h3000 + 32'(4 * k));
         if (k < 8) expect_pc(32'h3000 + 32'(4 * k));
         if (k == 6) check_eq("sf_not_frozen_7", {63'd0, frozen}, 64'd0);
         if (k == 7) check_eq("sf_frozen_8", {62'd0, frozen, full}, 64'b11);
         if (k == 7) check_eq("sf_no_ovf_yet", {63'd0, overflow}, 64'd0);
      end
      check_eq("sf_count", {60'd0, count}, 64'd8);
      check_eq("sf_ovf", {63'd0, overflow}, 64'd1);
      readout("sf", 1'b0);

      // RING: 11 writes keep the newest 8
      mode = 2'd1;
      pulse_arm();
      check_eq("ring_arm_clr", {62'd0, overflow, frozen}, 64'd0);
      for (int k = 0; k < 11; k++) begin
         capture(32'h3000 + 32'(4 * k));
         if (k >= 3) expect_pc(32'h3000 + 32'(4 * k));
      end
      check_eq("ring_not_frozen", {63'd0, frozen}, 64'd0);
      pulse_stop();
      check_eq("ring_count", {60'd0, count}, 64'd8);
      check_eq("ring_ovf_frozen", {62'd0, overflow, frozen}, 64'b11);
      readout("ring", 1'b0);

      // TRIGGER with two post-trigger entries, drained with rd_ready toggling
      mode = 2'd2;
      trig_pc = 32'h3010;
      post_cnt = 3'd2;
      pulse_arm();
      for (int k = 0; k < 7; k++) begin
         capture(32'h3000 + 32'(4 * k));
         expect_pc(32'h3000 + 32'(4 * k));
         if (k == 4) check_eq("trg_hit", {62'd0, triggered, frozen}, 64'b10);
         if (k == 5) check_eq("trg_post1", {63'd0, frozen}, 64'd0);
      end
      check_eq("trg_frozen", {62'd0, triggered, frozen}, 64'b11);
      check_eq("trg_count", {60'd0, count}, 64'd7);
      capture(32'h301C);
      check_eq("trg_ignore", {60'd0, count}, 64'd7);
      readout("trg", 1'b1);

      // TRIGGER with post_cnt=0 freezes on the trigger entry itself
      trig_pc = 32'h3000;
      post_cnt = 3'd0;
      pulse_arm();
      capture(32'h3000);
      expect_pc(32'h3000);
      check_eq("p0_frozen", {62'd0, triggered, frozen}, 64'b11);
      check_eq("p0_count", {60'd0, count}, 64'd1);
      capture(32'h3004);
      check_eq("p0_ignore", {60'd0, count}, 64'd1);
      readout("p0", 1'b1);

      // arm and stop together: arm wins, buffer left armed and empty
      mode = 2'd3;
      arm = 1'b1;
      stop = 1'b1;
      tick();
      arm = 1'b0;
      stop = 1'b0;
      check_eq("as_state", {58'd0, empty, full, rd_valid, triggered, overflow, frozen},
               64'b100000);
      check_eq("as_count", {60'd0, count}, 64'd0);
      capture(32'h3200);
      check_eq("as_capture", {60'd0, count}, 64'd1);
      check_eq("as_still_armed", {63'd0, frozen}, 64'd0);

      // reset in POST discards everything, then a fresh run behaves normally
      mode = 2'd2;
      trig_pc = 32'h3000;
      post_cnt = 3'd3;
      pulse_arm();
      capture(32'h3000);
      capture(32'h3004);
      check_eq("post_pre_rst", {60'd0, count}, 64'd2);
      rst = 1'b0;
      tick();
      check_reset_vals("post_rst");
      rst = 1'b1;
      mode = 2'd1;
      pulse_arm();
      capture(32'h3100);
      expect_pc(32'h3100);
      pulse_stop();
      check_eq("after_rst_count", {60'd0, count}, 64'd1);
      check_eq("after_rst_rdv", {63'd0, rd_valid}, 64'd1);
      readout("after_rst", 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
